mips_mc_ctrl: RTL and testbench

Multi-cycle control unit for the MIPS core. It sequences one instruction at a time through fetch, decode, execute, memory and writeback. It drives every datapath enable and mux select: PC, instruction register, register file, ALU and memory port. It performs a request/ready handshake with the shared instruction/data memory and halts on illegal encodings or memory timeouts.

---
 rtl/mips_mc_ctrl.sv | 230 +++++++++++++++++++++++
 tb/tb_mips_mc_ctrl.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_mc_ctrl.sv
// Multi-cycle MIPS control unit: sequences fetch/decode/execute/memory/writeback,
// drives all datapath strobes and selects, and halts on illegal encodings or memory timeouts.
`timescale 1ns/1ps
module mips_mc_ctrl #(
    parameter int unsigned WAIT_LIMIT = 15,
    parameter int unsigned CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic             alu_zero,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_we,
    output logic             i_or_d,
    output logic             ir_write,
    output logic             pc_write,
    output logic [1:0]       pc_src,
    output logic             reg_write,
    output logic             reg_dst,
    output logic             mem_to_reg,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [3:0]       alu_ctrl,
    output logic             halted,
    output logic [1:0]       halt_cause,
    output logic [CNT_W-1:0] retired,
    output logic [3:0]       state
);

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_MEM_ADDR = 4'd3,
        S_MEM_RD   = 4'd4,
        S_MEM_WB   = 4'd5,
        S_MEM_WR   = 4'd6,
        S_EXEC_R   = 4'd7,
        S_R_WB     = 4'd8,
        S_BRANCH   = 4'd9,
        S_JUMP     = 4'd10,
        S_EXEC_I   = 4'd11,
        S_I_WB     = 4'd12,
        S_HALT     = 4'd15
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00, OP_LW = 6'h23, OP_SW = 6'h2B;
    localparam logic [5:0] OP_BEQ = 6'h04, OP_J = 6'h02, OP_ADDI = 6'h08;
    localparam logic [5:0] FN_ADD = 6'd32, FN_SUB = 6'd34, FN_AND = 6'd36;
    localparam logic [5:0] FN_OR = 6'd37, FN_SLT = 6'd42;
    localparam logic [3:0] ALU_ADD = 4'b0010, ALU_SUB = 4'b0110, ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR = 4'b0001, ALU_SLT = 4'b0111;
    localparam logic [7:0] LIMIT_M1 = 8'(WAIT_LIMIT - 1);

    state_t     state_q, state_d;
    logic [7:0] wait_cnt;
    logic       at_limit;
    logic       set_illegal;
    logic       set_timeout;
    logic       retire;

    assign state    = state_q;
    // The access that would push the counter to WAIT_LIMIT is the last one allowed.
    assign at_limit = (wait_cnt == LIMIT_M1);

    always_comb begin
        // NOTE: every output gets a default first so no path through the case infers a latch.
        state_d     = state_q;
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        i_or_d      = 1'b0;
        ir_write    = 1'b0;
        pc_write    = 1'b0;
        pc_src      = 2'b00;
        reg_write   = 1'b0;
        reg_dst     = 1'b0;
        mem_to_reg  = 1'b0;
        alu_src_a   = 1'b0;
        alu_src_b   = 2'b00;
        alu_ctrl    = 4'b0000;
        halted      = 1'b0;
        set_illegal = 1'b0;
        set_timeout = 1'b0;
        retire      = 1'b0;

        case (state_q)
            S_IDLE: state_d = S_FETCH;
            S_FETCH: begin
                mem_req   = 1'b1;
                alu_src_b = 2'b01;
                alu_ctrl  = ALU_ADD;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = S_DECODE;
                end else if (at_limit) begin
                    set_timeout = 1'b1;
                    state_d     = S_HALT;
                end
            end
            S_DECODE: begin
                alu_src_b = 2'b11;
                alu_ctrl  = ALU_ADD;
                case (opcode)
                    OP_RTYPE: begin
                        case (funct)
                            FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT: state_d = S_EXEC_R;
                            default: begin
                                set_illegal = 1'b1;
                                state_d     = S_HALT;
                            end
                        endcase
                    end
                    OP_LW, OP_SW: state_d = S_MEM_ADDR;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_J:         state_d = S_JUMP;
                    OP_ADDI:      state_d = S_EXEC_I;
                    default: begin
                        set_illegal = 1'b1;
                        state_d     = S_HALT;
                    end
                endcase
            end
            S_EXEC_R: begin
                alu_src_a = 1'b1;
                case (funct)
                    FN_SUB:  alu_ctrl = ALU_SUB;
                    FN_AND:  alu_ctrl = ALU_AND;
                    FN_OR:   alu_ctrl = ALU_OR;
                    FN_SLT:  alu_ctrl = ALU_SLT;
                    default: alu_ctrl = ALU_ADD;
                endcase
                state_d = S_R_WB;
            end
            S_R_WB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
                retire    = 1'b1;
                state_d   = S_FETCH;
            end
            S_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                alu_ctrl  = ALU_ADD;
                state_d   = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
            end
            S_MEM_RD: begin
                mem_req = 1'b1;
                i_or_d  = 1'b1;
                if (mem_ready) begin
                    state_d = S_MEM_WB;
                end else if (at_limit) begin
                    set_timeout = 1'b1;
                    state_d     = S_HALT;
                end
            end
            S_MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                retire     = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEM_WR: begin
                mem_req = 1'b1;
                mem_we  = 1'b1;
                i_or_d  = 1'b1;
                if (mem_ready) begin
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end else if (at_limit) begin
                    set_timeout = 1'b1;
                    state_d     = S_HALT;
                end
            end
            S_BRANCH: begin
                alu_src_a = 1'b1;
                alu_ctrl  = ALU_SUB;
                pc_src    = 2'b01;
                pc_write  = alu_zero;
                retire    = 1'b1;
                state_d   = S_FETCH;
            end
            S_JUMP: begin
                pc_write = 1'b1;
                pc_src   = 2'b10;
                retire   = 1'b1;
                state_d  = S_FETCH;
            end
            S_EXEC_I: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                alu_ctrl  = ALU_ADD;
                state_d   = S_I_WB;
            end
            S_I_WB: begin
                reg_write = 1'b1;
                retire    = 1'b1;
                state_d   = S_FETCH;
            end
            S_HALT:  halted  = 1'b1;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            wait_cnt   <= '0;
            retired    <= '0;
            halt_cause <= 2'b00;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q <= state_d;
            if (retire)
                retired <= retired + CNT_W'(1);
            if (set_illegal)
                halt_cause <= 2'b01;
            else if (set_timeout)
                halt_cause <= 2'b10;
            // Only an unanswered request that stays in the same state keeps counting.
            if (state_d != state_q || mem_ready || !mem_req)
                wait_cnt <= '0;
            else
                wait_cnt <= wait_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// Directed bench for mips_mc_ctrl: instruction sequences, memory waits, timeout,
// illegal encodings, asynchronous reset and retired-counter wrap (CNT_W=3).
`timescale 1ns/1ps
module tb_mips_mc_ctrl;

    localparam int CNT_W      = 3;
    localparam int WAIT_LIMIT = 15;

    logic             clk;
    logic             rst;
    logic [5:0]       opcode;
    logic [5:0]       funct;
    logic             alu_zero;
    logic             mem_ready;
    logic             mem_req;
    logic             mem_we;
    logic             i_or_d;
    logic             ir_write;
    logic             pc_write;
    logic [1:0]       pc_src;
    logic             reg_write;
    logic             reg_dst;
    logic             mem_to_reg;
    logic             alu_src_a;
    logic [1:0]       alu_src_b;
    logic [3:0]       alu_ctrl;
    logic             halted;
    logic [1:0]       halt_cause;
    logic [CNT_W-1:0] retired;
    logic [3:0]       state;

    int vectors;
    int miscompares;
    int wb_cnt;

    mips_mc_ctrl #(.WAIT_LIMIT(WAIT_LIMIT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .alu_zero(alu_zero),
        .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we), .i_or_d(i_or_d),
        .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src), .reg_write(reg_write),
        .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_ctrl(alu_ctrl), .halted(halted),
        .halt_cause(halt_cause), .retired(retired), .state(state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic rdy, input logic zero);
        mem_ready = rdy;
        alu_zero  = zero;
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
            $error("check %s miscompared", tag);
        end
    endtask

    // Runs FETCH (zero-wait) and DECODE; returns one cycle into the dispatched state.
    task automatic fetch_decode(input logic [5:0] op, input logic [5:0] fn);
        opcode = op;
        funct  = fn;
        drive(1'b1, 1'b0);
        chk("fetch_state", {28'd0, state}, 32'd1);
        chk("fetch_ir_write", {31'd0, ir_write}, 32'd1);
        tick();
        drive(1'b1, 1'b0);
        chk("decode_state", {28'd0, state}, 32'd2);
        chk("decode_alu_src_b", {30'd0, alu_src_b}, 32'd3);
        tick();
    endtask

    logic [5:0] fn_tab [5];
    logic [3:0] alu_tab [5];
    logic [3:0] lw_st [11];
    logic       lw_rdy [11];

    initial begin
        vectors     = 0;
        miscompares = 0;
        fn_tab  = '{6'd32, 6'd34, 6'd36, 6'd37, 6'd42};
        alu_tab = '{4'b0010, 4'b0110, 4'b0000, 4'b0001, 4'b0111};
        lw_st   = '{4'd1, 4'd1, 4'd1, 4'd1, 4'd2, 4'd3, 4'd4, 4'd4, 4'd4, 4'd4, 4'd5};
        lw_rdy  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

        rst = 1'b1; opcode = 6'd0; funct = 6'd0; alu_zero = 1'b0; mem_ready = 1'b0;
        #3;
        chk("reset_state", {28'd0, state}, 32'd0);
        chk("reset_mem_req", {31'd0, mem_req}, 32'd0);
        chk("reset_alu_ctrl", {28'd0, alu_ctrl}, 32'd0);
        chk("reset_retired", {29'd0, retired}, 32'd0);
        chk("reset_halted", {31'd0, halted}, 32'd0);
        chk("reset_cause", {30'd0, halt_cause}, 32'd0);
        @(negedge clk) rst = 1'b0;
        tick();
        chk("first_fetch", {28'd0, state}, 32'd1);

        // R-type program: 4 cycles each
        for (int i = 0; i < 5; i++) begin
            fetch_decode(6'h00, fn_tab[i]);
            drive(1'b1, 1'b0);
            chk("exec_r_state", {28'd0, state}, 32'd7);
            chk("exec_r_alu_ctrl", {28'd0, alu_ctrl}, {28'd0, alu_tab[i]});
            chk("exec_r_src_a", {31'd0, alu_src_a}, 32'd1);
            tick();
            drive(1'b1, 1'b0);
            chk("r_wb_state", {28'd0, state}, 32'd8);
            chk("r_wb_reg_write", {31'd0, reg_write}, 32'd1);
            chk("r_wb_reg_dst", {31'd0, reg_dst}, 32'd1);
            chk("r_wb_mem_to_reg", {31'd0, mem_to_reg}, 32'd0);
            tick();
        end
        chk("rtype_retired", {29'd0, retired}, 32'd5);
        chk("rtype_back_fetch", {28'd0, state}, 32'd1);

        // lw with three wait cycles in FETCH and in MEM_RD: 11 cycles
        opcode = 6'h23;
        wb_cnt = 0;
        for (int c = 0; c < 11; c++) begin
            drive(lw_rdy[c], 1'b0);
            chk("lw_state", {28'd0, state}, {28'd0, lw_st[c]});
            if (lw_st[c] == 4'd1 || lw_st[c] == 4'd4)
                chk("lw_mem_req_held", {31'd0, mem_req}, 32'd1);
            if (reg_write && mem_to_reg)
                wb_cnt++;
            tick();
        end
        chk("lw_wb_once", wb_cnt, 32'd1);
        chk("lw_back_fetch", {28'd0, state}, 32'd1);
        chk("lw_retired", {29'd0, retired}, 32'd6);

        // beq taken then not taken; second retire wraps the 3-bit counter
        fetch_decode(6'h04, 6'd0);
        drive(1'b1, 1'b1);
        chk("beq_t_state", {28'd0, state}, 32'd9);
        chk("beq_t_pc_write", {31'd0, pc_write}, 32'd1);
        chk("beq_t_pc_src", {30'd0, pc_src}, 32'd1);
        tick();
        chk("beq_t_retired", {29'd0, retired}, 32'd7);
        fetch_decode(6'h04, 6'd0);
        drive(1'b1, 1'b0);
        chk("beq_nt_pc_write", {31'd0, pc_write}, 32'd0);
        chk("beq_nt_pc_src", {30'd0, pc_src}, 32'd1);
        tick();
        chk("wrap_retired_0", {29'd0, retired}, 32'd0);

        fetch_decode(6'h02, 6'd0);
        drive(1'b1, 1'b0);
        chk("j_state", {28'd0, state}, 32'd10);
        chk("j_pc_write", {31'd0, pc_write}, 32'd1);
        chk("j_pc_src", {30'd0, pc_src}, 32'd2);
        tick();
        chk("wrap_retired_1", {29'd0, retired}, 32'd1);
        chk("j_back_fetch", {28'd0, state}, 32'd1);

        // sw with no mem_ready: timeout after 15 request cycles
        fetch_decode(6'h2B, 6'd0);
        drive(1'b1, 1'b0);
        chk("mem_addr_state", {28'd0, state}, 32'd3);
        chk("mem_addr_src_b", {30'd0, alu_src_b}, 32'd2);
        tick();
        for (int k = 0; k < 15; k++) begin
            drive(1'b0, 1'b0);
            chk("sw_wait_state", {28'd0, state}, 32'd6);
            chk("sw_wait_mem_we", {31'd0, mem_we}, 32'd1);
            tick();
        end
        drive(1'b1, 1'b0);
        chk("timeout_state", {28'd0, state}, 32'd15);
        chk("timeout_halted", {31'd0, halted}, 32'd1);
        chk("timeout_cause", {30'd0, halt_cause}, 32'd2);
        chk("timeout_retired", {29'd0, retired}, 32'd1);
        tick();
        tick();
        chk("halt_sticky", {28'd0, state}, 32'd15);
        chk("halt_no_req", {31'd0, mem_req}, 32'd0);

        #2 rst = 1'b1;
        #1;
        chk("async_rst_state", {28'd0, state}, 32'd0);
        chk("async_rst_halted", {31'd0, halted}, 32'd0);
        chk("async_rst_cause", {30'd0, halt_cause}, 32'd0);
        chk("async_rst_retired", {29'd0, retired}, 32'd0);
        @(negedge clk) rst = 1'b0;
        tick();
        chk("rst_fetch", {28'd0, state}, 32'd1);

        fetch_decode(6'h08, 6'd0);
        drive(1'b1, 1'b0);
        chk("exec_i_state", {28'd0, state}, 32'd11);
        chk("exec_i_src_b", {30'd0, alu_src_b}, 32'd2);
        chk("exec_i_alu_ctrl", {28'd0, alu_ctrl}, 32'd2);
        tick();
        drive(1'b1, 1'b0);
        chk("i_wb_state", {28'd0, state}, 32'd12);
        chk("i_wb_reg_write", {31'd0, reg_write}, 32'd1);
        chk("i_wb_reg_dst", {31'd0, reg_dst}, 32'd0);
        tick();
        chk("addi_retired", {29'd0, retired}, 32'd1);

        // sw answered on the 15th request cycle: no timeout
        fetch_decode(6'h2B, 6'd0);
        drive(1'b1, 1'b0);
        tick();
        for (int k = 0; k < 14; k++) begin
            drive(1'b0, 1'b0);
            tick();
        end
        drive(1'b1, 1'b0);
        chk("sw_late_state", {28'd0, state}, 32'd6);
        tick();
        chk("sw_late_fetch", {28'd0, state}, 32'd1);
        chk("sw_late_halted", {31'd0, halted}, 32'd0);
        chk("sw_late_retired", {29'd0, retired}, 32'd2);

        // Reset mid MEM_RD
        fetch_decode(6'h23, 6'd0);
        drive(1'b1, 1'b0);
        tick();
        drive(1'b0, 1'b0);
        chk("mem_rd_state", {28'd0, state}, 32'd4);
        tick();
        drive(1'b0, 1'b0);
        chk("mem_rd_req", {31'd0, mem_req}, 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("rd_rst_mem_req", {31'd0, mem_req}, 32'd0);
        chk("rd_rst_i_or_d", {31'd0, i_or_d}, 32'd0);
        chk("rd_rst_state", {28'd0, state}, 32'd0);
        chk("rd_rst_retired", {29'd0, retired}, 32'd0);
        @(negedge clk) rst = 1'b0;
        tick();
        chk("rd_rst_fetch", {28'd0, state}, 32'd1);

        // Illegal opcode
        fetch_decode(6'h3F, 6'd0);
        drive(1'b1, 1'b0);
        chk("ill_op_state", {28'd0, state}, 32'd15);
        chk("ill_op_halted", {31'd0, halted}, 32'd1);
        chk("ill_op_cause", {30'd0, halt_cause}, 32'd1);
        chk("ill_op_retired", {29'd0, retired}, 32'd0);
        tick();
        tick();
        chk("ill_op_no_req", {31'd0, mem_req}, 32'd0);

        rst = 1'b1;
        #1;
        @(negedge clk) rst = 1'b0;
        tick();
        // Illegal funct
        fetch_decode(6'h00, 6'h05);
        drive(1'b1, 1'b0);
        chk("ill_fn_state", {28'd0, state}, 32'd15);
        chk("ill_fn_cause", {30'd0, halt_cause}, 32'd1);
        tick();
        chk("ill_fn_no_req", {31'd0, mem_req}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
